// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM source/controller (master) and the pwm_capture block (slave).
interface pwm_capture_if #(
  parameter int unsigned CNT_W = 12
);
  logic             enable;
  logic             pulse_in;
  logic [CNT_W-1:0] duty_out;
  logic [CNT_W-1:0] period_out;
  logic             valid;
  logic             stuck_high;
  logic             stuck_low;

  modport master (
    output enable, pulse_in,
    input  duty_out, period_out, valid, stuck_high, stuck_low
  );

  modport slave (
    input  enable, pulse_in,
    output duty_out, period_out, valid, stuck_high, stuck_low
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and rise-to-rise period of an asynchronous
// pulse in clk cycles, and flags a line that stops toggling (stuck high/low).
module pwm_capture #(
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 4000
) (
  input  logic          clk,
  input  logic          reset_n,
  pwm_capture_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_d1_q, s_d1_d;
  logic [CNT_W-1:0]       cnt_p_q, cnt_p_d;
  logic [CNT_W-1:0]       cnt_h_q, cnt_h_d;
  logic [CNT_W-1:0]       duty_q, duty_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic                   valid_q, valid_d;
  logic                   stuck_high_q, stuck_high_d;
  logic                   stuck_low_q, stuck_low_d;

  logic                   s_c;
  logic                   rise_c;
  logic                   timeout_c;
  logic [CNT_W-1:0]       cnt_p_inc_c;
  logic [CNT_W-1:0]       cnt_h_inc_c;

  // Synchroniser and edge detect; the chain runs regardless of enable.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.pulse_in};
    s_c    = sync_q[SYNC_STAGES-1];
    s_d1_d = s_c;
    rise_c = s_c & ~s_d1_q;
  end

  // Saturating increments; a raised flag suppresses repeat timeouts.
  always_comb begin
    cnt_p_inc_c = (cnt_p_q == CNT_MAX) ? CNT_MAX : cnt_p_q + CNT_ONE;
    cnt_h_inc_c = (cnt_h_q == CNT_MAX) ? CNT_MAX : cnt_h_q + CNT_ONE;
    timeout_c   = (cnt_p_q >= TMO_CNT) && !stuck_high_q && !stuck_low_q;
  end

  // Next-state and result logic.
  always_comb begin
    state_d      = state_q;
    cnt_p_d      = cnt_p_q;
    cnt_h_d      = cnt_h_q;
    duty_d       = duty_q;
    period_d     = period_q;
    valid_d      = 1'b0;
    stuck_high_d = stuck_high_q;
    stuck_low_d  = stuck_low_q;

    if (!bus.enable) begin
      state_d = ST_IDLE;
      cnt_p_d = '0;
      cnt_h_d = '0;
    end else if (rise_c) begin
      // A rise always wins over a coincident timeout.
      if (state_q == ST_LOW) begin
        duty_d   = cnt_h_q;
        period_d = cnt_p_q;
        valid_d  = 1'b1;
      end
      cnt_p_d      = CNT_ONE;
      cnt_h_d      = CNT_ONE;
      stuck_high_d = 1'b0;
      stuck_low_d  = 1'b0;
      state_d      = ST_HIGH;
    end else if (timeout_c) begin
      stuck_high_d = s_c;
      stuck_low_d  = ~s_c;
      duty_d       = s_c ? CNT_MAX : '0;
      period_d     = '0;
      valid_d      = 1'b1;
      cnt_p_d      = cnt_p_inc_c;
      cnt_h_d      = '0;
      state_d      = ST_IDLE;
    end else begin
      cnt_p_d = cnt_p_inc_c;
      if (state_q == ST_HIGH) begin
        if (s_c) begin
          cnt_h_d = cnt_h_inc_c;
        end else begin
          state_d = ST_LOW;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      sync_q       <= '0;
      s_d1_q       <= 1'b0;
      cnt_p_q      <= '0;
      cnt_h_q      <= '0;
      duty_q       <= '0;
      period_q     <= '0;
      valid_q      <= 1'b0;
      stuck_high_q <= 1'b0;
      stuck_low_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      s_d1_q       <= s_d1_d;
      cnt_p_q      <= cnt_p_d;
      cnt_h_q      <= cnt_h_d;
      duty_q       <= duty_d;
      period_q     <= period_d;
      valid_q      <= valid_d;
      stuck_high_q <= stuck_high_d;
      stuck_low_q  <= stuck_low_d;
    end
  end

  assign bus.duty_out   = duty_q;
  assign bus.period_out = period_q;
  assign bus.valid      = valid_q;
  assign bus.stuck_high = stuck_high_q;
  assign bus.stuck_low  = stuck_low_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Randomised scoreboard bench for pwm_capture: a waveform-level model predicts
// each measurement/fault report, and a monitor compares them as valid strobes appear.
module tb_pwm_capture;

  localparam int unsigned CNT_W       = 12;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned TIMEOUT     = 4000;
  localparam int          ALL_ONES    = (1 << CNT_W) - 1;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  pwm_capture_if #(.CNT_W(CNT_W)) bus ();

  pwm_capture #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int duty;
    int period;
    bit sh;
    bit sl;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Waveform-level model: what has the line done since the last rising edge?
  bit m_en     = 1'b1;
  bit m_prev   = 1'b0;
  bit m_have   = 1'b0;
  bit m_flag   = 1'b0;
  bit m_inhigh = 1'b0;
  int m_p      = 0;
  int m_h      = 0;
  int last_duty   = 0;
  int last_period = 0;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp_v, $time);
    end
  endtask

  task automatic push(input int d, input int p, input bit sh, input bit sl);
    exp_t e;
    e.duty = d; e.period = p; e.sh = sh; e.sl = sl;
    exp_q.push_back(e);
    last_duty   = d;
    last_period = p;
  endtask

  task automatic model_reset();
    m_prev = 1'b0; m_have = 1'b0; m_flag = 1'b0; m_inhigh = 1'b0;
    m_p = 0; m_h = 0; last_duty = 0; last_period = 0;
  endtask

  // One input cycle at level lvl as seen by the model.
  task automatic m_tick(input bit lvl);
    if (!m_en) begin
      m_p = 0; m_h = 0; m_have = 1'b0; m_inhigh = 1'b0;
    end else if (lvl && !m_prev) begin
      if (m_have) push(m_h, m_p, 1'b0, 1'b0);
      m_have = 1'b1; m_p = 1; m_h = 1; m_inhigh = 1'b1; m_flag = 1'b0;
    end else if (!m_flag && m_p >= int'(TIMEOUT)) begin
      push(lvl ? ALL_ONES : 0, 0, lvl, !lvl);
      m_flag = 1'b1; m_have = 1'b0; m_inhigh = 1'b0; m_h = 0;
      m_p = (m_p + 1 > ALL_ONES) ? ALL_ONES : m_p + 1;
    end else begin
      m_p = (m_p + 1 > ALL_ONES) ? ALL_ONES : m_p + 1;
      if (m_inhigh) begin
        if (lvl) m_h++;
        else     m_inhigh = 1'b0;
      end
    end
    m_prev = lvl;
  endtask

  task automatic cycle(input bit lvl);
    bus.pulse_in = lvl;
    m_tick(lvl);
    @(posedge clk);
    #1;
  endtask

  task automatic seg(input int h, input int p);
    for (int i = 0; i < p; i++) cycle(i < h);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_duty"},       int'(bus.duty_out),   0);
    check({tag, "_period"},     int'(bus.period_out), 0);
    check({tag, "_valid"},      int'(bus.valid),      0);
    check({tag, "_stuck_high"}, int'(bus.stuck_high), 0);
    check({tag, "_stuck_low"},  int'(bus.stuck_low),  0);
  endtask

  // Monitor: every valid strobe must match the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && bus.valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid duty=%0d period=%0d sh=%0d sl=%0d at t=%0t",
                   bus.duty_out, bus.period_out, bus.stuck_high, bus.stuck_low, $time);
        end else begin
          e = exp_q.pop_front();
          check("sb_duty",       int'(bus.duty_out),   e.duty);
          check("sb_period",     int'(bus.period_out), e.period);
          check("sb_stuck_high", int'(bus.stuck_high), int'(e.sh));
          check("sb_stuck_low",  int'(bus.stuck_low),  int'(e.sl));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int h;
    int waited;
    bus.enable   = 1'b1;
    bus.pulse_in = 1'b0;
    reset_n      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    model_reset();

    // Fixed 3/10 waveform.
    repeat (6) seg(3, 10);

    // Random waveforms plus narrowest/widest duty extremes.
    for (int i = 0; i < 30; i++) begin
      p = int'($urandom_range(60, 2));
      h = int'($urandom_range(p - 1, 1));
      seg(h, p);
    end
    seg(1, 2);
    seg(59, 60);
    seg(1, 2);
    seg(1, 5);

    // Disable for 20 cycles in the middle of a low phase.
    for (int i = 0; i < 15; i++) cycle(i < 3);
    bus.enable = 1'b0;
    m_en       = 1'b0;
    repeat (20) cycle(1'b0);
    check("disabled_duty_hold",   int'(bus.duty_out),   last_duty);
    check("disabled_period_hold", int'(bus.period_out), last_period);
    bus.enable = 1'b1;
    m_en       = 1'b1;
    repeat (10) cycle(1'b0);
    seg(4, 12);
    seg(5, 15);
    seg(2, 8);

    // Line stuck low after activity.
    repeat (4100) cycle(1'b0);
    check("stuck_low_set",    int'(bus.stuck_low),  1);
    check("stuck_low_duty",   int'(bus.duty_out),   0);
    check("stuck_low_period", int'(bus.period_out), 0);
    repeat (6) cycle(1'b1);
    check("stuck_low_cleared", int'(bus.stuck_low), 0);
    repeat (6) cycle(1'b0);
    seg(3, 10);
    seg(7, 11);

    // Line stuck high.
    repeat (4100) cycle(1'b1);
    check("stuck_high_set",    int'(bus.stuck_high), 1);
    check("stuck_high_duty",   int'(bus.duty_out),   ALL_ONES);
    check("stuck_high_period", int'(bus.period_out), 0);
    repeat (10) cycle(1'b0);
    repeat (3) seg(3, 10);

    // Reset pulse partway through a high phase.
    seg(3, 10);
    repeat (8) cycle(1'b1);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    repeat (4) cycle(1'b1);
    repeat (8) cycle(1'b0);
    repeat (4) seg(3, 10);
    seg(2, 6);

    // Drain outstanding predictions.
    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      cycle(1'b0);
      waited++;
    end
    repeat (5) cycle(1'b0);
    check("drain_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
